// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and parameter legality checks for the FIFO burst reader.
// State encodings are fixed so that other tools and viewers decode them consistently.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int MIN_BURST_LEN   = 1;
    localparam int MIN_TIMEOUT_CYC = 1;

    // A burst must fit in the FIFO count range so beat_cnt never wraps.
    function automatic bit burst_len_ok(int burst_len, int awidth);
        return (burst_len >= MIN_BURST_LEN) && (burst_len <= (1 << awidth) - 1);
    endfunction

    function automatic bit timeout_ok(int timeout_cyc);
        return timeout_cyc >= MIN_TIMEOUT_CYC;
    endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Framed valid/ready stream (data plus sop/eop markers) carried between a burst source and its consumer.
interface fifo_burst_reader_if #(
    parameter int DWIDTH = 8
);
    logic              valid;
    logic              ready;
    logic [DWIDTH-1:0] data;
    logic              sop;
    logic              eop;

    modport master (output valid, output data, output sop, output eop, input ready);
    modport slave  (input valid, input data, input sop, input eop, output ready);
endinterface

// File: rtl/fifo_burst_reader_stream_out_reg.sv
// stream_out_reg: a single registered valid/ready stage holding data/sop/eop.
// Any stream source can reuse it; can_load tells the source when a new beat may be captured.
module stream_out_reg #(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DWIDTH-1:0] load_data,
    input  logic              load_sop,
    input  logic              load_eop,
    output logic              can_load,
    fifo_burst_reader_if.master m
);

    logic              valid_q, valid_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;

    assign can_load = ~valid_q | m.ready;

    // Payload holds when the beat drains without a refill; it is don't-care once valid drops.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            sop_d   = load_sop;
            eop_d   = load_eop;
        end else if (valid_q && m.ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign m.valid = valid_q;
    assign m.data  = data_q;
    assign m.sop   = sop_q;
    assign m.eop   = eop_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops BURST_LEN-word bursts from a show-ahead FIFO and emits them as framed stream bursts.
// Define FIFO_BURST_READER_TIMEOUT_EN to flush a partial burst after TIMEOUT_CYC idle cycles.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DWIDTH      = 8,
    parameter int AWIDTH      = 6,
    parameter int BURST_LEN   = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              fifo_rd,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_rdata,
    input  logic [AWIDTH-1:0] fifo_cnt,
    fifo_burst_reader_if.master m_if,
    output logic              busy
);

    if (!burst_len_ok(BURST_LEN, AWIDTH) || !timeout_ok(TIMEOUT_CYC)) begin : g_bad_cfg
        $error("fifo_burst_reader: BURST_LEN or TIMEOUT_CYC out of range");
    end

    localparam logic [AWIDTH-1:0] BURST_LEN_W = AWIDTH'(BURST_LEN);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic              busy_q, busy_d;
    logic [AWIDTH-1:0] len;
    logic              active;
    logic              load;
    logic              can_load;
    logic              last_beat;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    logic [TW-1:0]     timer_q, timer_d;
    logic [AWIDTH-1:0] flush_len_q, flush_len_d;

    assign len = (state_q == FLUSH) ? flush_len_q : BURST_LEN_W;
`else
    assign len = BURST_LEN_W;
`endif

    assign active    = (state_q == BURST) || (state_q == FLUSH);
    assign load      = active & ~fifo_empty & can_load;
    assign fifo_rd   = load;
    assign last_beat = (beat_cnt_q == len - AWIDTH'(1));

    // Burst entry wins over the timeout; a burst ends on the load of its last beat.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        flush_len_d = flush_len_q;
`endif
        case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                if (fifo_cnt >= BURST_LEN_W) begin
                    state_d = BURST;
                end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                else if (!fifo_empty && (timer_q == TW'(TIMEOUT_CYC - 1))) begin
                    state_d     = FLUSH;
                    flush_len_d = fifo_cnt;
                end
`endif
            end
            BURST, FLUSH: begin
                if (load) begin
                    if (last_beat) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + AWIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    always_comb begin
        timer_d = '0;
        if ((state_q == IDLE) && (state_d == IDLE) && !fifo_empty && (fifo_cnt < BURST_LEN_W)) begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q     <= '0;
            flush_len_q <= '0;
        end else begin
            timer_q     <= timer_d;
            flush_len_q <= flush_len_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign busy = busy_q;

    stream_out_reg #(
        .DWIDTH (DWIDTH)
    ) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (fifo_rdata),
        .load_sop  (beat_cnt_q == '0),
        .load_eop  (last_beat),
        .can_load  (can_load),
        .m         (m_if)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: the bench plays the FIFO and the consumer, and a scoreboard
// built from written words (grouped into BURST_LEN-word frames) predicts every accepted beat.
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int BL = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } beat_t;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          fifo_rd;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic [AW-1:0] fifo_cnt   = '0;
    logic          busy;

    fifo_burst_reader_if #(.DWIDTH(DW)) m_if ();

    fifo_burst_reader #(
        .DWIDTH      (DW),
        .AWIDTH      (AW),
        .BURST_LEN   (BL),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_rd    (fifo_rd),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_cnt   (fifo_cnt),
        .m_if       (m_if),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q[$];
    beat_t         exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            idx = 0;
    int            beats = 0;
    int            rd_count = 0;
    int            cyc = 0;
    int            first_rd = -1;
    int            last_rd = -1;
    int            first_beat = -1;
    int            stall_left = 0;
    int            b0 = 0;
    logic          stall_prev = 1'b0;
    beat_t         held;
    beat_t         last_acc;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void syncFifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = fifo_empty ? '0 : fifo_q[0];
        fifo_cnt   = AW'(fifo_q.size());
    endfunction

    // Frame position follows the word's place in the stream since the last reset.
    function automatic void pushExp(input logic [DW-1:0] w);
        exp_q.push_back('{d: w, sop: (idx == 0), eop: (idx == BL - 1)});
        idx = (idx + 1) % BL;
    endfunction

    function automatic void rebuildModel();
        exp_q.delete();
        idx = 0;
        foreach (fifo_q[i]) pushExp(fifo_q[i]);
        stall_prev = 1'b0;
    endfunction

    task automatic applyStimulus(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        pushExp(w);
        syncFifo();
    endtask

    // One clock: sample at the falling edge, then apply FIFO pops just after the rising edge.
    task automatic stepCycle();
        beat_t e;
        beat_t got;
        logic  rd_s, v_s, r_s;
        @(negedge clk);
        rd_s = fifo_rd;
        v_s  = m_if.valid;
        r_s  = m_if.ready;
        got  = '{d: m_if.data, sop: m_if.sop, eop: m_if.eop};
        if (stall_prev) begin
            checkOutput("hold_valid", 32'(v_s), 32'd1);
            checkOutput("hold_beat", 32'(got), 32'(held));
        end
        if (v_s && !r_s) checkOutput("rd_during_stall", 32'(rd_s), 32'd0);
        if (rd_s) begin
            checkOutput("rd_when_empty", 32'(fifo_empty), 32'd0);
            rd_count++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (v_s && r_s) begin
            if (first_beat < 0) first_beat = cyc;
            checkOutput("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("beat_data", 32'(got.d), 32'(e.d));
                checkOutput("beat_sop", 32'(got.sop), 32'(e.sop));
                checkOutput("beat_eop", 32'(got.eop), 32'(e.eop));
            end
            beats++;
            last_acc = got;
        end
        stall_prev = v_s && !r_s;
        held       = got;
        @(posedge clk);
        #1;
        if (rd_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
        syncFifo();
        cyc++;
    endtask

    task automatic assertResetChecks();
        rst_n = 1'b0;
        #2;
        checkOutput("rst_valid", 32'(m_if.valid), 32'd0);
        checkOutput("rst_data", 32'(m_if.data), 32'd0);
        checkOutput("rst_sop", 32'(m_if.sop), 32'd0);
        checkOutput("rst_eop", 32'(m_if.eop), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    endtask

    task automatic doReset(input bit clearFifo);
        assertResetChecks();
        repeat (2) @(posedge clk);
        #1;
        if (clearFifo) fifo_q.delete();
        syncFifo();
        rst_n = 1'b1;
        rebuildModel();
    endtask

    task automatic clearStats();
        cyc = 0; first_rd = -1; last_rd = -1; first_beat = -1; rd_count = 0;
    endtask

    initial begin
        m_if.ready = 1'b1;
        syncFifo();
        #1;
        doReset(1'b1);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
        $display("[TB] partial flush after timeout");
        clearStats();
        applyStimulus(8'hA0);
        applyStimulus(8'hA1);
        exp_q.delete();
        exp_q.push_back('{d: 8'hA0, sop: 1'b1, eop: 1'b0});
        exp_q.push_back('{d: 8'hA1, sop: 1'b0, eop: 1'b1});
        repeat (40) stepCycle();
        checkOutput("timeout_first_rd", 32'(first_rd), 32'd16);
        checkOutput("timeout_rd_count", 32'(rd_count), 32'd2);
        checkOutput("timeout_exp_left", 32'(exp_q.size()), 32'd0);
        doReset(1'b1);
`else
        $display("[TB] underfill");
        clearStats();
        for (int i = 1; i <= 3; i++) applyStimulus(8'(i));
        repeat (1000) stepCycle();
        checkOutput("underfill_rd", 32'(rd_count), 32'd0);
        checkOutput("underfill_valid", 32'(m_if.valid), 32'd0);
        checkOutput("underfill_busy", 32'(busy), 32'd0);
        doReset(1'b1);
`endif

        $display("[TB] single burst");
        clearStats();
        for (int i = 0; i < 4; i++) applyStimulus(8'h10 + 8'(i));
        repeat (12) stepCycle();
        checkOutput("single_rd_count", 32'(rd_count), 32'd4);
        checkOutput("single_first_rd", 32'(first_rd), 32'd1);
        checkOutput("single_rd_span", 32'(last_rd - first_rd), 32'd3);
        checkOutput("single_first_beat", 32'(first_beat), 32'd2);
        checkOutput("single_exp_left", 32'(exp_q.size()), 32'd0);
        checkOutput("single_busy_end", 32'(busy), 32'd0);

        $display("[TB] backpressure on 0x11");
        clearStats();
        stall_left = 3;
        for (int i = 0; i < 4; i++) applyStimulus(8'h10 + 8'(i));
        for (int i = 0; i < 20; i++) begin
            m_if.ready = !(m_if.valid && m_if.data == 8'h11 && stall_left > 0);
            if (!m_if.ready) stall_left--;
            stepCycle();
        end
        m_if.ready = 1'b1;
        checkOutput("bp_stalls_done", 32'(stall_left), 32'd0);
        checkOutput("bp_rd_count", 32'(rd_count), 32'd4);
        checkOutput("bp_exp_left", 32'(exp_q.size()), 32'd0);

        $display("[TB] back-to-back bursts");
        b0 = beats;
        for (int i = 0; i < 8; i++) applyStimulus(8'h20 + 8'(i));
        repeat (20) stepCycle();
        checkOutput("b2b_beats", 32'(beats - b0), 32'd8);
        checkOutput("b2b_exp_left", 32'(exp_q.size()), 32'd0);
        checkOutput("b2b_busy_end", 32'(busy), 32'd0);

        $display("[TB] random traffic");
        repeat (400) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 60) applyStimulus(8'($urandom));
            m_if.ready = ($urandom_range(0, 3) != 0);
            stepCycle();
        end
        m_if.ready = 1'b1;
        repeat (60) stepCycle();
        checkOutput("rand_residual_small", 32'(fifo_q.size() < BL), 32'd1);
        checkOutput("rand_exp_vs_fifo", 32'(exp_q.size()), 32'(fifo_q.size()));
        checkOutput("rand_busy_end", 32'(busy), 32'd0);

        $display("[TB] reset mid-burst");
        doReset(1'b1);
        b0 = beats;
        for (int i = 0; i < 8; i++) applyStimulus(8'h30 + 8'(i));
        for (int i = 0; i < 20 && (beats - b0) < 2; i++) stepCycle();
        checkOutput("mid_reached_beat2", 32'(beats - b0), 32'd2);
        doReset(1'b0);
        b0 = beats;
        for (int i = 0; i < 20 && beats == b0; i++) stepCycle();
        checkOutput("post_reset_beat", 32'(beats - b0), 32'd1);
        checkOutput("post_reset_sop", 32'(last_acc.sop), 32'd1);
        checkOutput("post_reset_data", 32'(last_acc.d), 32'h33);
        repeat (10) stepCycle();
        checkOutput("post_reset_exp_left", 32'(exp_q.size()), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
